// File: rtl/uart_tx_drain_if.sv
// FIFO-side handshake between an upstream FIFO and the UART transmitter
// that drains it; master is the draining transmitter, slave is the FIFO.
interface uart_tx_drain_if #(
    parameter int DBIT = 8
);
    logic            fifo_empty;
    logic [DBIT-1:0] fifo_data;
    logic            fifo_rd;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd
    );
endinterface

// File: rtl/uart_tx_drain.sv
// UART transmitter that pops words from an upstream FIFO and serialises them
// LSB first (start, DBIT data, stop) with a 16x oversampled baud divider.
module uart_tx_drain #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 163,
    parameter int DVSR_W  = 8
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_drain_if.master fifo,
    output logic            tx,
    output logic            tx_busy
);

    localparam int S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_r;
    logic [DVSR_W-1:0] div_r;
    logic [S_W-1:0]    s_r;
    logic [N_W-1:0]    n_r;
    logic [DBIT-1:0]   b_r;
    logic              tx_r;
    logic              busy_r;

    logic              tick_s;
    logic              pop_s;
    logic [DBIT-1:0]   b_shift_s;

    // Baud tick, pop strobe (masked while reset is held) and next shift value.
    always_comb begin
        tick_s    = (div_r == DVSR_W'(DVSR - 1));
        b_shift_s = b_r >> 1;
        if ((state_r == IDLE) && !fifo.fifo_empty && !rst) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    assign fifo.fifo_rd = pop_s;
    assign tx           = tx_r;
    assign tx_busy      = busy_r;

    // Frame FSM; tx and tx_busy are loaded with the value of the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            div_r   <= '0;
            s_r     <= '0;
            n_r     <= '0;
            b_r     <= '0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    div_r <= '0;
                    if (pop_s) begin
                        b_r     <= fifo.fifo_data;
                        s_r     <= '0;
                        state_r <= START;
                        tx_r    <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        tx_r   <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                START: begin
                    div_r <= tick_s ? '0 : div_r + DVSR_W'(1);
                    if (tick_s) begin
                        if (s_r == S_W'(15)) begin
                            s_r     <= '0;
                            n_r     <= '0;
                            state_r <= DATA;
                            tx_r    <= b_r[0];
                        end else begin
                            s_r <= s_r + S_W'(1);
                        end
                    end else begin
                        s_r <= s_r;
                    end
                end
                DATA: begin
                    div_r <= tick_s ? '0 : div_r + DVSR_W'(1);
                    if (tick_s) begin
                        if (s_r == S_W'(15)) begin
                            s_r <= '0;
                            b_r <= b_shift_s;
                            if (n_r == N_W'(DBIT - 1)) begin
                                state_r <= STOP;
                                tx_r    <= 1'b1;
                            end else begin
                                n_r  <= n_r + N_W'(1);
                                tx_r <= b_shift_s[0];
                            end
                        end else begin
                            s_r <= s_r + S_W'(1);
                        end
                    end else begin
                        s_r <= s_r;
                    end
                end
                STOP: begin
                    div_r <= tick_s ? '0 : div_r + DVSR_W'(1);
                    if (tick_s) begin
                        if (s_r == S_W'(SB_TICK - 1)) begin
                            s_r     <= '0;
                            state_r <= IDLE;
                            tx_r    <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            s_r <= s_r + S_W'(1);
                        end
                    end else begin
                        s_r <= s_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    div_r   <= '0;
                    s_r     <= '0;
                    n_r     <= '0;
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain with DVSR=4 (64 clocks per bit); a second
// instance with SB_TICK=32 covers the two-stop-bit frame length.
module tb_uart_tx_drain;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_drain_if #(.DBIT(8)) if_a ();
    uart_tx_drain_if #(.DBIT(8)) if_b ();

    logic tx_a, busy_a, tx_b, busy_b;

    // FIFO model for instance A
    logic [7:0] q_words [8];
    int         q_idx = 0;
    int         q_cnt = 0;
    int         rd_pulses_a = 0;
    int         rd_pulses_b = 0;
    logic       noise_en;
    logic [7:0] noise_r = 8'h00;
    logic       b_empty;
    logic [7:0] b_data;

    assign if_a.fifo_empty = (q_idx >= q_cnt);
    assign if_a.fifo_data  = noise_en ? noise_r : q_words[q_idx[2:0]];
    assign if_b.fifo_empty = b_empty;
    assign if_b.fifo_data  = b_data;

    uart_tx_drain #(.DBIT(8), .SB_TICK(16), .DVSR(4), .DVSR_W(8)) dut_a (
        .clk(clk), .rst(rst), .fifo(if_a), .tx(tx_a), .tx_busy(busy_a)
    );

    uart_tx_drain #(.DBIT(8), .SB_TICK(32), .DVSR(4), .DVSR_W(8)) dut_b (
        .clk(clk), .rst(rst), .fifo(if_b), .tx(tx_b), .tx_busy(busy_b)
    );

    // Pop the FIFO model and count read strobes seen at each clock edge.
    always @(posedge clk) begin
        if (if_a.fifo_rd === 1'b1) begin
            q_idx       <= q_idx + 1;
            rd_pulses_a <= rd_pulses_a + 1;
        end
        if (if_b.fifo_rd === 1'b1) begin
            rd_pulses_b <= rd_pulses_b + 1;
        end
    end

    // Random garbage on the data bus when enabled.
    always @(negedge clk) begin
        noise_r = 8'($urandom);
    end

    logic sel;
    wire  mon_tx   = sel ? tx_b : tx_a;
    wire  mon_busy = sel ? busy_b : busy_a;
    wire  mon_rd   = sel ? if_b.fifo_rd : if_a.fifo_rd;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        q_words[q_cnt[2:0]] = d;
        q_cnt = q_cnt + 1;
    endtask

    // Called just before the capturing edge; checks every cycle from T+1 on.
    task automatic frame_check(input logic [7:0] d, input int stop_clk,
                               input logic next_rd, input string tag);
        int   bad;
        int   busy_bad;
        int   rd_bad;
        int   nclk;
        logic e;
        busy_bad = 0;
        rd_bad   = 0;
        for (int k = 0; k < 10; k++) begin
            bad  = 0;
            nclk = (k == 9) ? stop_clk : 64;
            if (k == 0)      e = 1'b0;
            else if (k == 9) e = 1'b1;
            else             e = d[k-1];
            for (int j = 0; j < nclk; j++) begin
                @(negedge clk);
                if (mon_tx !== e)       bad++;
                if (mon_busy !== 1'b1)  busy_bad++;
                if (mon_rd !== 1'b0)    rd_bad++;
            end
            check($sformatf("%s bit%0d", tag, k), bad, 0);
        end
        check({tag, " busy_in_frame"}, busy_bad, 0);
        check({tag, " rd_in_frame"}, rd_bad, 0);
        @(negedge clk);
        check({tag, " busy_end"}, mon_busy, 1'b0);
        check({tag, " tx_end"}, mon_tx, 1'b1);
        check({tag, " rd_end"}, mon_rd, next_rd);
    endtask

    initial begin
        int bad;
        rst      = 1'b1;
        sel      = 1'b0;
        noise_en = 1'b0;
        b_empty  = 1'b0;
        b_data   = 8'h12;
        repeat (3) @(negedge clk);
        check("rst tx_a", tx_a, 1'b1);
        check("rst busy_a", busy_a, 1'b0);
        check("rst tx_b", tx_b, 1'b1);
        check("rst rd_b_masked", if_b.fifo_rd, 1'b0);
        b_empty = 1'b1;
        rst     = 1'b0;

        // Long idle with nothing queued
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || if_a.fifo_rd !== 1'b0) bad++;
            if (tx_b !== 1'b1 || busy_b !== 1'b0 || if_b.fifo_rd !== 1'b0) bad++;
        end
        check("idle2000", bad, 0);

        // Single word 0xA5
        push_word(8'hA5);
        #1 check("a5 rd", if_a.fifo_rd, 1'b1);
        frame_check(8'hA5, 64, 1'b0, "a5");
        check("a5 pulses", rd_pulses_a, 1);

        // Three queued words, back to back
        @(negedge clk);
        push_word(8'h00);
        push_word(8'hFF);
        push_word(8'h3C);
        #1 check("q rd", if_a.fifo_rd, 1'b1);
        frame_check(8'h00, 64, 1'b1, "q00");
        frame_check(8'hFF, 64, 1'b1, "qFF");
        frame_check(8'h3C, 64, 1'b0, "q3C");
        check("q pulses", rd_pulses_a, 4);

        // Reset in the middle of the data phase of 0x55
        @(negedge clk);
        push_word(8'h55);
        #1 check("55 rd", if_a.fifo_rd, 1'b1);
        repeat (192) @(negedge clk);
        check("55 mid tx_is_d1", tx_a, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst tx", tx_a, 1'b1);
        check("midrst busy", busy_a, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || if_a.fifo_rd !== 1'b0) bad++;
        end
        check("post_rst idle", bad, 0);
        check("post_rst pulses", rd_pulses_a, 5);
        push_word(8'hC3);
        #1 check("c3 rd", if_a.fifo_rd, 1'b1);
        frame_check(8'hC3, 64, 1'b0, "c3");

        // Data bus toggles after capture
        @(negedge clk);
        push_word(8'h81);
        #1 check("81 rd", if_a.fifo_rd, 1'b1);
        @(posedge clk);
        #1 noise_en = 1'b1;
        frame_check(8'h81, 64, 1'b0, "81noise");
        noise_en = 1'b0;
        check("final pulses a", rd_pulses_a, 7);

        // Two stop bits: 128-clock stop phase, 704-clock frame
        sel = 1'b1;
        @(negedge clk);
        b_empty = 1'b0;
        #1 check("sb32 rd", if_b.fifo_rd, 1'b1);
        @(posedge clk);
        #1;
        b_empty = 1'b1;
        b_data  = 8'hFF;
        frame_check(8'h12, 128, 1'b0, "sb32");
        check("sb32 pulses", rd_pulses_b, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_drain.md
UART_TX_DRAIN -- requirements
Module: uart_tx_drain

Interface
REQ-001 The block SHALL have parameter DBIT, default 8: data bits per frame.
REQ-002 The block SHALL have parameter SB_TICK, default 16: stop-bit length in baud ticks (16 = 1 stop bit, 32 = 2 stop bits).
REQ-003 The block SHALL have parameter DVSR, default 163: clocks per baud tick (16x oversampling; 50 MHz / 19200 baud).
REQ-004 The block SHALL have parameter DVSR_W, default 8: width of the baud divider counter.
REQ-005 The block SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port fifo_empty, input, 1 bit: upstream FIFO empty flag.
REQ-008 The block SHALL have port fifo_data, input, DBIT bits: upstream FIFO head word, valid whenever fifo_empty=0.
REQ-009 The block SHALL have port fifo_rd, output, 1 bit: pop strobe to the upstream FIFO.
REQ-010 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-011 The block SHALL have port tx_busy, output, 1 bit: high while a frame is in progress.

Function
REQ-012 The block SHALL implement FSM states IDLE, START, DATA and STOP.
REQ-013 The block SHALL also hold a baud divider (0..DVSR-1), a 4-bit tick counter s, a bit counter n (0..DBIT-1) and a DBIT-bit shift register b.
REQ-014 The baud tick SHALL be a one-clock pulse when the divider equals DVSR-1; the divider then wraps to 0.
REQ-015 The divider SHALL be held at 0 in IDLE, so every bit lasts exactly 16*DVSR clocks.
REQ-016 In IDLE with fifo_empty=1, tx SHALL be 1 and fifo_rd 0; the block SHALL wait indefinitely.
REQ-017 In IDLE with fifo_empty=0 in cycle T, fifo_rd SHALL be 1 combinationally for cycle T only, fifo_data SHALL be captured into b, and s SHALL be cleared; the FSM SHALL enter START at T+1.
REQ-018 fifo_rd SHALL never assert while fifo_empty=1, nor outside IDLE.
REQ-019 In START, tx SHALL be 0; on a tick with s=15, s and n SHALL clear and the FSM SHALL go to DATA; otherwise s SHALL increment on each tick.
REQ-020 In DATA, tx SHALL equal b[0]; on a tick with s=15, s SHALL clear and b SHALL shift right by one.
REQ-021 At that same DATA tick, the FSM SHALL go to STOP if n=DBIT-1, and SHALL increment n otherwise.
REQ-022 Data SHALL be sent LSB first, with no parity.
REQ-023 In STOP, tx SHALL be 1; on a tick with s=SB_TICK-1, the FSM SHALL go to IDLE; otherwise s SHALL increment on each tick.
REQ-024 s SHALL be wide enough for SB_TICK-1.
REQ-025 tx SHALL be driven from a register, glitch-free; its first low cycle SHALL be T+1.
REQ-026 Frame length SHALL be (1+DBIT)*16*DVSR + SB_TICK*DVSR clocks from T+1.
REQ-027 Back-to-back frames SHALL have exactly one IDLE clock, with tx=1, between the end of STOP and the next fifo_rd.
REQ-028 tx_busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-029 fifo_data changes after capture SHALL NOT affect the frame in progress.

Reset
REQ-030 On rst=1, at any time including mid-frame, the block SHALL immediately set state=IDLE, tx=1, fifo_rd=0, tx_busy=0, and clear divider, s, n and b.
REQ-031 A partially sent byte SHALL be lost and SHALL NOT be re-read.
REQ-032 After rst deasserts, the block SHALL behave as REQ-016/REQ-017 from the next clock edge.

Verification (DVSR=4, DBIT=8, SB_TICK=16; bit = 64 clocks)
REQ-033 fifo_empty=1 for 2000 clocks -> tx=1, fifo_rd=0 and tx_busy=0 throughout.
REQ-034 Single word 0xA5 presented at cycle T -> fifo_rd is high only in cycle T; tx is 0 for 64 clocks, then 1,0,1,0,0,1,0,1 at 64 clocks each, then 1 for 64 clocks; tx_busy falls at T+641.
REQ-035 Three words 0x00, 0xFF, 0x3C queued -> three frames; exactly 1 idle clock between each STOP end and the next fifo_rd; exactly 3 fifo_rd pulses.
REQ-036 rst pulsed mid-DATA of 0x55 -> tx=1 in the same cycle; no further pulse until fifo_empty=0; the next frame is a complete, correct frame of the new head word.
REQ-037 fifo_data toggled randomly during a frame of 0x81 -> the serialised bits are still 0x81.
REQ-038 SB_TICK=32 with 0x12 -> stop phase is 128 clocks; total frame length is 704 clocks.
